// File: rtl/imem_pkg.sv
// Shared types for the LEGv8 instruction memory pipeline.
// The FSM state, the response-buffer depth and the default response record.
package imem_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } imem_state_t;

    localparam int RSP_DEPTH = 2;
    localparam int RSP_CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int INSTR_W   = 32;

    typedef struct packed {
        logic [INSTR_W-1:0] data;
        logic               err;
    } imem_rsp_t;

endpackage

// File: rtl/imem_pipe_rsp_fifo2.sv
// Two-entry in-order response buffer. Slot 0 is always the head, so after the
// last pop the head keeps showing the most recently delivered word.
module rsp_fifo2
    import imem_pkg::*;
#(
    parameter type entry_t = imem_rsp_t
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  entry_t               din,
    input  logic                 pop,
    output entry_t               dout,
    output logic [RSP_CNT_W-1:0] count
);

    entry_t               slot_reg  [RSP_DEPTH];
    entry_t               slot_next [RSP_DEPTH];
    logic [RSP_CNT_W-1:0] count_reg;
    logic [RSP_CNT_W-1:0] count_next;
    logic [RSP_CNT_W-1:0] wr_pos;
    logic                 do_pop;
    logic                 do_push;

    always_comb begin
        slot_next  = slot_reg;
        do_pop     = pop && (count_reg != '0);
        do_push    = push && ((count_reg != RSP_CNT_W'(RSP_DEPTH)) || do_pop);
        wr_pos     = count_reg - RSP_CNT_W'(do_pop);
        count_next = count_reg + RSP_CNT_W'(do_push) - RSP_CNT_W'(do_pop);

        // Shift only when a second entry exists; a lone head stays put on pop.
        if (do_pop && (count_reg == RSP_CNT_W'(RSP_DEPTH))) begin
            slot_next[0] = slot_reg[1];
        end
        if (do_push) begin
            slot_next[wr_pos[0]] = din;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < RSP_DEPTH; i++) begin
                slot_reg[i] <= '0;
            end
            count_reg <= '0;
        end else begin
            slot_reg  <= slot_next;
            count_reg <= count_next;
        end
    end

    assign dout  = slot_reg[0];
    assign count = count_reg;

endmodule

// File: rtl/imem_pipe.sv
// Instruction memory with valid/ready fetch, 2-deep response buffering,
// a zero-clear sweep after reset and a runtime program-load port.
module imem_pipe
    import imem_pkg::*;
#(
    parameter int                ADDR_W   = 6,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 64,
    parameter logic [DATA_W-1:0] OOB_WORD = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              busy
);

    localparam int                CNT_W    = $clog2(DEPTH + 1);
    localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DEPTH - 1);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              err;
    } rsp_t;

    imem_state_t          state_reg;
    imem_state_t          state_next;
    logic [CNT_W-1:0]     cnt_reg;
    logic [CNT_W-1:0]     cnt_next;
    logic                 inflight_reg;
    logic                 rd_err_reg;
    logic [DATA_W-1:0]    rd_data_reg;
    logic [DATA_W-1:0]    mem [DEPTH];

    logic                 req_in_range;
    logic                 ld_in_range;
    logic                 accept;
    logic                 pop;
    logic                 wr_en;
    logic [IDX_W-1:0]     wr_idx;
    logic [DATA_W-1:0]    wr_data;
    logic [RSP_CNT_W-1:0] buf_count;
    logic [RSP_CNT_W-1:0] occ;
    rsp_t                 push_entry;
    rsp_t                 head;

    // Range checks are one bit wider than the address so DEPTH itself fits.
    assign req_in_range = {1'b0, req_addr} < DEPTH_X;
    assign ld_in_range  = {1'b0, ld_addr} < DEPTH_X;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        wr_en      = 1'b0;
        wr_idx     = cnt_reg[IDX_W-1:0];
        wr_data    = '0;
        busy       = 1'b0;
        unique case (state_reg)
            INIT: begin
                busy  = 1'b1;
                wr_en = 1'b1;
                if (cnt_reg == LAST_CNT) begin
                    state_next = RUN;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            RUN: begin
                if (ld_en && ld_in_range) begin
                    wr_en   = 1'b1;
                    wr_idx  = ld_addr[IDX_W-1:0];
                    wr_data = ld_data;
                end
            end
            default: state_next = INIT;
        endcase
    end

    // A slot freed by this cycle's pop can be refilled, keeping full throughput.
    assign pop       = rsp_valid && rsp_ready;
    assign occ       = buf_count + RSP_CNT_W'(inflight_reg);
    assign req_ready = (state_reg == RUN) && !ld_en
                       && ((occ < RSP_CNT_W'(RSP_DEPTH)) || pop);
    assign accept    = req_valid && req_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= INIT;
            cnt_reg      <= '0;
            inflight_reg <= 1'b0;
            rd_err_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            inflight_reg <= accept;
            if (accept) begin
                rd_err_reg <= !req_in_range;
            end
        end
    end

    // Array and read register carry no reset so they map onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
        if (accept && req_in_range) begin
            rd_data_reg <= mem[req_addr[IDX_W-1:0]];
        end
    end

    always_comb begin
        push_entry.data = rd_err_reg ? OOB_WORD : rd_data_reg;
        push_entry.err  = rd_err_reg;
    end

    rsp_fifo2 #(
        .entry_t (rsp_t)
    ) u_rsp_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (inflight_reg),
        .din   (push_entry),
        .pop   (pop),
        .dout  (head),
        .count (buf_count)
    );

    assign rsp_valid = (buf_count != '0);
    assign rsp_data  = head.data;
    assign rsp_err   = head.err;

endmodule

// File: tb/tb_imem_pipe.sv
// Bench for imem_pipe: a 64-word and a 40-word instance checked against a
// queue/array reference model, a vector table and hand-built corner sequences.
module tb_imem_pipe;

    localparam logic [31:0] OOB1 = 32'hd503201f;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid [2];
    logic        req_ready [2];
    logic [5:0]  req_addr  [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_data  [2];
    logic        rsp_err   [2];
    logic        ld_en     [2];
    logic [5:0]  ld_addr   [2];
    logic [31:0] ld_data   [2];
    logic        busy      [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    imem_pipe u_dut64 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]),
        .rsp_err(rsp_err[0]), .ld_en(ld_en[0]), .ld_addr(ld_addr[0]),
        .ld_data(ld_data[0]), .busy(busy[0])
    );

    imem_pipe #(.DEPTH(40), .OOB_WORD(OOB1)) u_dut40 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]),
        .rsp_err(rsp_err[1]), .ld_en(ld_en[1]), .ld_addr(ld_addr[1]),
        .ld_data(ld_data[1]), .busy(busy[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Reference model: memory image, expected-response queue, init countdown.
    for (genvar gi = 0; gi < 2; gi++) begin : g_mon
        localparam int          DEP = (gi == 0) ? 64 : 40;
        localparam logic [31:0] OOB = (gi == 0) ? 32'h0 : OOB1;
        logic [32:0] exp_q [$];
        logic [31:0] mdl_mem [64];
        logic [32:0] e;
        int          init_left;
        logic        in_init;
        logic        stall_prev;

        always @(negedge clk) begin
            if (!reset) begin
                exp_q.delete();
                for (int i = 0; i < 64; i++) mdl_mem[i] = '0;
                init_left  = DEP;
                stall_prev = 1'b0;
            end else begin
                in_init = (init_left > 0);
                check("busy", busy[gi], in_init);
                if (in_init) begin
                    check("ready_in_init", req_ready[gi], 0);
                    init_left--;
                end
                if (stall_prev) check("hold_valid", rsp_valid[gi], 1);
                if (rsp_valid[gi]) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_rsp dut%0d: got %h, required no response", gi, rsp_data[gi]);
                    end else begin
                        e = exp_q[0];
                        check("rsp_data", rsp_data[gi], e[31:0]);
                        check("rsp_err", rsp_err[gi], e[32]);
                        if (rsp_ready[gi]) begin
                            void'(exp_q.pop_front());
                            $display("dut%0d rsp data=%h err=%b", gi, rsp_data[gi], rsp_err[gi]);
                        end
                    end
                end
                if (req_valid[gi] && req_ready[gi]) begin
                    if (req_addr[gi] < DEP) exp_q.push_back({1'b0, mdl_mem[req_addr[gi]]});
                    else                    exp_q.push_back({1'b1, OOB});
                end
                if (ld_en[gi] && !in_init && (ld_addr[gi] < DEP)) mdl_mem[ld_addr[gi]] = ld_data[gi];
                stall_prev = rsp_valid[gi] && !rsp_ready[gi];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input int d, input logic [5:0] a);
        int k;
        req_valid[d] = 1'b1;
        req_addr[d]  = a;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (req_ready[d]) break;
        end
        check("accept_timeout", k < 50, 1);
        step();
        req_valid[d] = 1'b0;
    endtask

    task automatic fetch_get(input int d, input logic [5:0] a, output logic [31:0] data, output logic err);
        int k;
        fetch(d, a);
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rsp_valid[d]) break;
        end
        check("rsp_timeout", k < 20, 1);
        data = rsp_data[d];
        err  = rsp_err[d];
        step();
    endtask

    task automatic load(input int d, input logic [5:0] a, input logic [31:0] v);
        ld_en[d]   = 1'b1;
        ld_addr[d] = a;
        ld_data[d] = v;
        @(negedge clk);
        check("ready_during_load", req_ready[d], 0);
        step();
        ld_en[d] = 1'b0;
    endtask

    typedef struct {
        int          dut;
        logic        do_load;
        logic [5:0]  ld_a;
        logic [31:0] ld_v;
        logic [5:0]  rd_a;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t        vecs [9];
    logic [31:0] prog [4];
    logic [31:0] got_d;
    logic        got_e;
    logic        got;
    int          nb;
    int          acc;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, 1'b1, 6'd7,  32'hdeadbeef, 6'd7,  32'hdeadbeef, 1'b0};
        vecs[1] = '{0, 1'b0, 6'd0,  32'h0,        6'd5,  32'h00000000, 1'b0};
        vecs[2] = '{0, 1'b1, 6'd63, 32'h0000abcd, 6'd63, 32'h0000abcd, 1'b0};
        vecs[3] = '{1, 1'b0, 6'd0,  32'h0,        6'd45, OOB1,         1'b1};
        vecs[4] = '{1, 1'b1, 6'd39, 32'hcafef00d, 6'd39, 32'hcafef00d, 1'b0};
        vecs[5] = '{1, 1'b1, 6'd50, 32'h12345678, 6'd39, 32'hcafef00d, 1'b0};
        vecs[6] = '{1, 1'b0, 6'd0,  32'h0,        6'd40, OOB1,         1'b1};
        vecs[7] = '{1, 1'b0, 6'd0,  32'h0,        6'd63, OOB1,         1'b1};
        vecs[8] = '{1, 1'b1, 6'd0,  32'h11112222, 6'd0,  32'h11112222, 1'b0};
        prog[0] = 32'h8b1f03e0;
        prog[1] = 32'h8b1f0001;
        prog[2] = 32'hf8000000;
        prog[3] = 32'hf8008001;

        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_addr[d] = '0; rsp_ready[d] = 1'b1;
            ld_en[d] = 1'b0; ld_addr[d] = '0; ld_data[d] = '0;
        end
        repeat (3) step();
        for (int d = 0; d < 2; d++) begin
            check("reset_rsp_valid", rsp_valid[d], 0);
            check("reset_rsp_data", rsp_data[d], 0);
            check("reset_rsp_err", rsp_err[d], 0);
            check("reset_busy", busy[d], 1);
            check("reset_req_ready", req_ready[d], 0);
        end

        // Init sweep length.
        reset = 1'b1;
        nb = 0;
        while (busy[0] && nb < 200) begin
            step();
            nb++;
        end
        check("init_cycles", nb, 64);
        check("ready_after_init", req_ready[0], 1);
        check("busy40_done", busy[1], 0);

        // Vector table: optional load, then fetch and compare.
        for (int v = 0; v < 9; v++) begin
            if (vecs[v].do_load) load(vecs[v].dut, vecs[v].ld_a, vecs[v].ld_v);
            fetch_get(vecs[v].dut, vecs[v].rd_a, got_d, got_e);
            check("vec_data", got_d, vecs[v].exp_data);
            check("vec_err", got_e, vecs[v].exp_err);
        end

        // Program load then back-to-back fetches with no bubbles.
        for (int i = 0; i < 4; i++) load(0, 6'(i), prog[i]);
        for (int i = 0; i < 6; i++) begin
            req_valid[0] = (i < 4);
            req_addr[0]  = 6'(i);
            @(negedge clk);
            if (i < 4) check("tp_ready", req_ready[0], 1);
            if (i >= 2) begin
                check("tp_valid", rsp_valid[0], 1);
                check("tp_data", rsp_data[0], prog[i-2]);
            end
            step();
        end
        req_valid[0] = 1'b0;
        @(negedge clk);
        check("tp_idle", rsp_valid[0], 0);
        step();

        // Backpressure: two accepts, stable head, then drain and resume.
        rsp_ready[0] = 1'b0;
        req_valid[0] = 1'b1;
        req_addr[0]  = 6'd0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            got = req_ready[0];
            step();
            if (got) begin
                acc++;
                req_addr[0] = 6'(acc);
            end
        end
        check("bp_accepts", acc, 2);
        @(negedge clk);
        check("bp_ready_low", req_ready[0], 0);
        check("bp_head", rsp_data[0], prog[0]);
        step();
        rsp_ready[0] = 1'b1;
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            got = req_ready[0];
            step();
            if (got) begin
                acc++;
                req_addr[0] = 6'(2 + acc);
            end
        end
        check("bp_resume", acc, 4);
        req_valid[0] = 1'b0;
        repeat (4) step();

        // Randomised traffic against the model.
        for (int c = 0; c < 400; c++) begin
            for (int d = 0; d < 2; d++) begin
                req_valid[d] = ($urandom_range(0, 3) != 0);
                req_addr[d]  = 6'($urandom_range(0, 63));
                rsp_ready[d] = ($urandom_range(0, 2) != 0);
                ld_en[d]     = ($urandom_range(0, 7) == 0);
                ld_addr[d]   = 6'($urandom_range(0, 63));
                ld_data[d]   = $urandom;
            end
            step();
        end
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; ld_en[d] = 1'b0; rsp_ready[d] = 1'b1;
        end
        repeat (5) step();
        check("drain_d0", g_mon[0].exp_q.size(), 0);
        check("drain_d1", g_mon[1].exp_q.size(), 0);

        // Reset with two responses buffered.
        load(0, 6'd7, 32'hdeadbeef);
        rsp_ready[0] = 1'b0;
        fetch(0, 6'd7);
        fetch(0, 6'd7);
        repeat (2) step();
        check("pre_reset_valid", rsp_valid[0], 1);
        check("pre_reset_data", rsp_data[0], 32'hdeadbeef);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("reset_async_valid", rsp_valid[0], 0);
        check("reset_async_busy", busy[0], 1);
        check("reset_async_data", rsp_data[0], 0);
        repeat (2) step();
        reset = 1'b1;
        rsp_ready[0] = 1'b1;
        nb = 0;
        while (busy[0] && nb < 200) begin
            step();
            nb++;
        end
        check("reinit_cycles", nb, 64);
        fetch_get(0, 6'd7, got_d, got_e);
        check("cleared_data", got_d, 32'h0);
        check("cleared_err", got_e, 0);
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
